ibex_csr_access_ctrl: RTL and testbench
=======================================

// Module: ibex_csr_access_ctrl
// PURPOSE
// Initiator side of the CSR primitive interface. Arbitrates single read/write/set/clear requests onto a bank of
// NumCsr CSR primitives: drives their wr_en/wr_data, samples their rd_data/rd_error and returns a registered response.
// Background scrubber polls each primitive's rd_error round-robin while idle; any integrity fault raises sticky alert_o.
// PARAMETERS
// NumCsr       8   number of attached CSR primitives (>=2)
// Width        32  CSR data width
// ScrubPeriod  16  idle cycles between scrub checks (>=1)
// (AddrW = $clog2(NumCsr), localparam)
// PORTS
// clk_i           in   1             clock
// rst_ni          in   1             async active-low reset
// req_i           in   1             access request
// op_i            in   2             0=READ 1=WRITE 2=SET 3=CLEAR
// addr_i          in   AddrW+1       CSR index; values >= NumCsr are illegal
// wdata_i         in   Width         write data / bit mask
// gnt_o           out  1             request accepted this cycle
// rvalid_o        out  1             response valid (1 cycle pulse)
// rdata_o         out  Width         old CSR value (0 on error)
// err_o           out  1             response error, qualified by rvalid_o
// csr_rd_data_i   in   NumCsr*Width  concatenated CSR read data, index i at [i*Width +: Width]
// csr_rd_error_i  in   NumCsr        per-CSR shadow mismatch
// csr_wr_en_o     out  NumCsr        one-hot write enable
// csr_wr_data_o   out  Width         shared write data
// alert_o         out  1             sticky integrity alert
// BEHAVIOUR
// Clock/reset: one clock clk_i; reset asynchronous, active-low (rst_ni).
// Reset: state=IDLE; gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, csr_wr_en_o=0, csr_wr_data_o=0, alert_o=0.
//   Reset: scrub_idx=0, scrub_cnt=ScrubPeriod-1.
// FSM states: IDLE, ACCESS, RESP.
//   - IDLE: gnt_o=1 (combinational, state==IDLE); req_i&gnt_o latches op/addr/wdata, goes to ACCESS.
//   - ACCESS: csr_wr_en_o and csr_wr_data_o are combinational from the latched request.
//   - ACCESS: if addr>=NumCsr or csr_rd_error_i[addr] -> err=1, rdata=0, no write.
//   - ACCESS: otherwise old=csr_rd_data_i[addr], computed per op:
//       - READ: no write.
//       - WRITE: new=wdata.
//       - SET: new=old|wdata.
//       - CLEAR: new=old&~wdata.
//   - ACCESS: SET/CLEAR with wdata==0 suppresses the write; WRITE always writes.
//   - ACCESS: on a write, csr_wr_en_o[addr]=1 for exactly this one cycle; csr_wr_data_o=new.
//   - ACCESS: csr_wr_data_o=0 whenever no write is issued.
//   - ACCESS: rdata/err registered; go to RESP.
//   - RESP: rvalid_o=1, rdata_o=old, err_o per above; always returns to IDLE (next grant one cycle later).
// Latency: accept cycle N -> write cycle N+1 -> rvalid cycle N+2; throughput 1 request / 3 cycles.
// rvalid_o/err_o/rdata_o are registered outputs; rdata_o and err_o hold their value until the next response.
// Scrubber:
//   - scrub_cnt decrements only in IDLE cycles with req_i=0.
//   - At scrub_cnt==0 on such a cycle: check csr_rd_error_i[scrub_idx] and set alert if high.
//   - Same cycle: scrub_idx wraps NumCsr-1 -> 0, scrub_cnt reloads to ScrubPeriod-1.
//   - req_i in IDLE has priority; scrub_cnt holds at 0 until the first idle cycle without req_i.
// alert_o: set by access rd_error (not by illegal addr) or by a scrub hit; cleared only by reset.
// Illegal addr: err_o=1, no csr_wr_en_o bit ever asserted, alert unaffected.
// Reset mid-operation (ACCESS/RESP): abort, no partial response, outputs return to reset values asynchronously.
// csr_wr_en_o is never multi-hot; assert onehot0 and known on csr_wr_en_o, gnt_o, rvalid_o.
// TESTING
// 1. Set CSR2=0x0000_00F0; req op=SET addr=2 wdata=0x0F at cycle N.
//    -> gnt N, csr_wr_en_o=0b100 and csr_wr_data_o=0xFF at N+1, rvalid N+2 with rdata=0xF0, err=0.
// 2. op=CLEAR addr=1 wdata=0; CSR1=0x1234.
//    -> no csr_wr_en_o bit asserted, rvalid with rdata=0x1234, err=0.
// 3. addr=8 (NumCsr=8), op=WRITE.
//    -> csr_wr_en_o stays 0, rvalid err=1 rdata=0, alert_o stays 0.
// 4. Force csr_rd_error_i[5]=1, idle bench.
//    -> alert_o rises within 8*16 idle cycles; a later READ addr=5 gives err=1; alert_o stays high until rst_ni.
// 5. Back-to-back req_i held high with 3 WRITEs.
//    -> grants every 3rd cycle, scrub_cnt frozen, writes land in request order.
// 6. Assert rst_ni=0 during ACCESS of a WRITE.
//    -> csr_wr_en_o drops to 0 immediately, no rvalid, gnt_o=1 on the first cycle after release.

Source files
------------

// File: rtl/ibex_csr_access_ctrl.sv
// ibex_csr_access_ctrl
// Initiator side of the CSR primitive interface. Serialises single READ/WRITE/SET/CLEAR
// requests onto a bank of CSR primitives, returns a registered response, and runs a
// background scrubber that polls each primitive's shadow-mismatch flag while idle.
// Any integrity fault raises a sticky alert that only reset clears.
module ibex_csr_access_ctrl #(
    parameter int unsigned NumCsr      = 8,
    parameter int unsigned Width       = 32,
    parameter int unsigned ScrubPeriod = 16,
    localparam int unsigned AddrW      = $clog2(NumCsr)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    req_i,
    input  logic [1:0]              op_i,
    input  logic [AddrW:0]          addr_i,
    input  logic [Width-1:0]        wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [Width-1:0]        rdata_o,
    output logic                    err_o,

    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i,
    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,

    output logic                    alert_o
);

    // Wide enough to hold ScrubPeriod-1; a period of 1 still needs one bit.
    localparam int unsigned CntW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e           state_q;
    op_e              op_q;
    logic [AddrW:0]   addr_q;
    logic [Width-1:0] wdata_q;
    logic             rvalid_q;
    logic [Width-1:0] rdata_q;
    logic             err_q;
    logic             alert_q;
    logic [AddrW-1:0] scrub_idx_q;
    logic [CntW-1:0]  scrub_cnt_q;

    logic [Width-1:0] old_val;
    logic             sel_err;
    logic             addr_illegal;
    logic             acc_err;
    logic [Width-1:0] new_val;
    logic             do_write;
    logic             scrub_fire;
    logic             scrub_hit;
    logic             access_hit;

    // The grant is gated by rst_ni so it reads 0 while reset is held, even though the
    // state register already sits in IDLE.
    assign gnt_o = (state_q == ST_IDLE) && rst_ni;

    // Select the addressed primitive's data and error flag; nothing is selected for an
    // out-of-range index, so an illegal address never aliases onto a real CSR.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        old_val = '0;
        sel_err = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (addr_q == (AddrW+1)'(i)) begin
                old_val = csr_rd_data_i[i*Width +: Width];
                sel_err = csr_rd_error_i[i];
            end
        end
    end

    assign addr_illegal = (addr_q >= (AddrW+1)'(NumCsr));
    assign acc_err      = addr_illegal || sel_err;

    // Compute the post-access value and decide whether this access really writes.
    // SET/CLEAR with an empty mask would not change anything, so they stay silent.
    always_comb begin
        new_val  = old_val;
        do_write = 1'b0;
        unique case (op_q)
            OP_READ: begin
                new_val  = old_val;
                do_write = 1'b0;
            end
            OP_WRITE: begin
                new_val  = wdata_q;
                do_write = 1'b1;
            end
            OP_SET: begin
                new_val  = old_val | wdata_q;
                do_write = (wdata_q != '0);
            end
            OP_CLEAR: begin
                new_val  = old_val & ~wdata_q;
                do_write = (wdata_q != '0);
            end
            default: begin
                new_val  = old_val;
                do_write = 1'b0;
            end
        endcase
        do_write = do_write && (state_q == ST_ACCESS) && !acc_err;
    end

    // Drive the one-hot write strobe and shared write bus; both stay zero unless writing.
    always_comb begin
        csr_wr_en_o   = '0;
        csr_wr_data_o = '0;
        if (do_write) begin
            csr_wr_data_o = new_val;
            for (int i = 0; i < NumCsr; i++) begin
                if (addr_q == (AddrW+1)'(i)) begin
                    csr_wr_en_o[i] = 1'b1;
                end
            end
        end
    end

    // Request FSM: latch in IDLE, access the primitive in ACCESS, present the response in RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            rvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        op_q    <= op_e'(op_i);
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rvalid_q <= 1'b1;
                    err_q    <= acc_err;
                    rdata_q  <= acc_err ? '0 : old_val;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // The scrubber only advances on idle cycles nobody wants; a pending request wins.
    assign scrub_fire = (state_q == ST_IDLE) && !req_i && (scrub_cnt_q == '0);
    assign scrub_hit  = scrub_fire && csr_rd_error_i[scrub_idx_q];
    // An illegal address is a software error, not an integrity fault.
    assign access_hit = (state_q == ST_ACCESS) && !addr_illegal && sel_err;

    // Scrub countdown and round-robin index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scrub_idx_q <= '0;
            scrub_cnt_q <= CntW'(ScrubPeriod - 1);
        end else if ((state_q == ST_IDLE) && !req_i) begin
            if (scrub_cnt_q == '0) begin
                scrub_cnt_q <= CntW'(ScrubPeriod - 1);
                scrub_idx_q <= (scrub_idx_q == AddrW'(NumCsr - 1)) ? '0
                                                                   : scrub_idx_q + AddrW'(1);
            end else begin
                scrub_cnt_q <= scrub_cnt_q - CntW'(1);
            end
        end
    end

    // Sticky integrity alert, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alert_q <= 1'b0;
        end else if (scrub_hit || access_hit) begin
            alert_q <= 1'b1;
        end
    end

    assign alert_o = alert_q;

    a_wr_en_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(csr_wr_en_o));
    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({csr_wr_en_o, gnt_o, rvalid_o}));

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Testbench for ibex_csr_access_ctrl: emulates a bank of CSR primitives and checks every
// access against a behavioural model of the access rules, plus scrubber and reset scenarios.
module tb_ibex_csr_access_ctrl;

    localparam int NumCsr      = 8;
    localparam int Width       = 32;
    localparam int ScrubPeriod = 16;
    localparam int AddrW       = 3;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    req_i;
    logic [1:0]              op_i;
    logic [AddrW:0]          addr_i;
    logic [Width-1:0]        wdata_i;
    logic                    gnt_o;
    logic                    rvalid_o;
    logic [Width-1:0]        rdata_o;
    logic                    err_o;
    logic [NumCsr*Width-1:0] csr_rd_data_i;
    logic [NumCsr-1:0]       csr_rd_error_i;
    logic [NumCsr-1:0]       csr_wr_en_o;
    logic [Width-1:0]        csr_wr_data_o;
    logic                    alert_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // CSR primitive bank model
    logic [Width-1:0]        mem [NumCsr];
    logic [NumCsr-1:0]       err_flags;
    logic                    pre_en;
    int                      pre_idx;
    logic [Width-1:0]        pre_val;
    logic [Width+7:0]        wlog [$];

    ibex_csr_access_ctrl #(
        .NumCsr      (NumCsr),
        .Width       (Width),
        .ScrubPeriod (ScrubPeriod)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .op_i           (op_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .csr_rd_data_i  (csr_rd_data_i),
        .csr_rd_error_i (csr_rd_error_i),
        .csr_wr_en_o    (csr_wr_en_o),
        .csr_wr_data_o  (csr_wr_data_o),
        .alert_o        (alert_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Primitive bank: bench preload or a write strobe from the DUT updates the stored value.
    always @(posedge clk_i) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else begin
            for (int i = 0; i < NumCsr; i++) begin
                if (csr_wr_en_o[i]) begin
                    mem[i] <= csr_wr_data_o;
                    wlog.push_back({8'(i), csr_wr_data_o});
                end
            end
        end
    end

    always_comb begin
        csr_rd_data_i = '0;
        for (int i = 0; i < NumCsr; i++) csr_rd_data_i[i*Width +: Width] = mem[i];
    end

    assign csr_rd_error_i = err_flags;

    // Expected outcome of one access from the architectural rules and current bank contents.
    function automatic void model(input logic [1:0] op, input int addr, input logic [31:0] wd,
                                  output logic e_err, output logic [31:0] e_rd,
                                  output logic [NumCsr-1:0] e_we, output logic [31:0] e_wd);
        logic [31:0] old;
        e_err = 1'b0; e_rd = '0; e_we = '0; e_wd = '0;
        if (addr >= NumCsr) begin e_err = 1'b1; return; end
        if (err_flags[addr]) begin e_err = 1'b1; return; end
        old  = mem[addr];
        e_rd = old;
        if (op == OP_WRITE) begin
            e_we = NumCsr'(1) << addr; e_wd = wd;
        end else if (op == OP_SET && wd != 0) begin
            e_we = NumCsr'(1) << addr; e_wd = old | wd;
        end else if (op == OP_CLEAR && wd != 0) begin
            e_we = NumCsr'(1) << addr; e_wd = old & ~wd;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk_i); @(negedge clk_i);
        pre_en = 1'b0;
    endtask

    // One access, entered and left at a falling edge; returns the cycle it was granted.
    task automatic do_access(input logic [1:0] op, input int addr, input logic [31:0] wd,
                             input bit hold_req, input string tag, output int acc_cyc);
        logic e_err; logic [31:0] e_rd, e_wd; logic [NumCsr-1:0] e_we;
        int budget;
        req_i = 1'b1; op_i = op; addr_i = 4'(addr); wdata_i = wd;
        budget = 0; acc_cyc = -1;
        while (!gnt_o && budget < 10) begin @(negedge clk_i); budget++; end
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL %s grant: gnt=%b after %0d cycles, want 1", tag, gnt_o, budget);
            req_i = 1'b0; return;
        end
        model(op, addr, wd, e_err, e_rd, e_we, e_wd);
        acc_cyc = cyc;
        @(posedge clk_i); @(negedge clk_i);
        if (!hold_req) req_i = 1'b0;
        checks++;
        if (csr_wr_en_o !== e_we || csr_wr_data_o !== e_wd || gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s access: we=%b wd=%h gnt=%b rv=%b, want we=%b wd=%h gnt=0 rv=0",
                     tag, csr_wr_en_o, csr_wr_data_o, gnt_o, rvalid_o, e_we, e_wd);
        end
        @(negedge clk_i);
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== e_rd || err_o !== e_err || csr_wr_en_o !== '0) begin
            errors++;
            $display("FAIL %s resp: rv=%b rdata=%h err=%b we=%b, want rv=1 rdata=%h err=%b we=0",
                     tag, rvalid_o, rdata_o, err_o, csr_wr_en_o, e_rd, e_err);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
        err_flags = '0; pre_en = 1'b0; pre_idx = 0; pre_val = '0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== '0 || err_o !== 1'b0 ||
            csr_wr_en_o !== '0 || csr_wr_data_o !== '0 || alert_o !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: gnt=%b rv=%b rdata=%h err=%b we=%b wd=%h alert=%b, want all 0",
                     gnt_o, rvalid_o, rdata_o, err_o, csr_wr_en_o, csr_wr_data_o, alert_o);
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL reset release gnt: got %b want 1", gnt_o);
        end
        @(negedge clk_i);
        for (int i = 0; i < NumCsr; i++) preload(i, 32'h1000_0000 + 32'(i));
    endtask

    task automatic test_set();
        int c;
        preload(2, 32'h0000_00F0);
        do_access(OP_SET, 2, 32'h0F, 1'b0, "set", c);
        checks++;
        if (mem[2] !== 32'h0000_00FF) begin
            errors++; $display("FAIL set result: csr2=%h want 000000ff", mem[2]);
        end
    endtask

    task automatic test_clear_zero();
        int c; int n;
        preload(1, 32'h0000_1234);
        n = wlog.size();
        do_access(OP_CLEAR, 1, 32'h0, 1'b0, "clear0", c);
        checks++;
        if (wlog.size() != n || mem[1] !== 32'h0000_1234) begin
            errors++; $display("FAIL clear0 nowrite: writes=%0d csr1=%h want 0 writes csr1=00001234",
                               wlog.size() - n, mem[1]);
        end
    endtask

    task automatic test_illegal();
        int c; int n;
        n = wlog.size();
        do_access(OP_WRITE, 8, 32'hDEAD_BEEF, 1'b0, "illegal8", c);
        do_access(OP_SET, 15, 32'hFFFF_FFFF, 1'b0, "illegal15", c);
        checks++;
        if (wlog.size() != n || alert_o !== 1'b0) begin
            errors++; $display("FAIL illegal side effects: writes=%0d alert=%b want 0 0",
                               wlog.size() - n, alert_o);
        end
    endtask

    task automatic test_hold();
        int c; logic [31:0] exp;
        preload(7, 32'hCAFE_0007);
        exp = 32'hCAFE_0007;
        do_access(OP_READ, 7, 32'h0, 1'b0, "hold", c);
        repeat (2) @(negedge clk_i);
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== exp || err_o !== 1'b0) begin
            errors++; $display("FAIL hold: rv=%b rdata=%h err=%b want rv=0 rdata=%h err=0",
                               rvalid_o, rdata_o, err_o, exp);
        end
    endtask

    task automatic test_random();
        int c;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] op; int addr; logic [31:0] wd;
            op   = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, 9);
            wd   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            do_access(op, addr, wd, 1'b0, "random", c);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk_i);
        end
        checks++;
        if (alert_o !== 1'b0) begin
            errors++; $display("FAIL random alert: got %b want 0", alert_o);
        end
    endtask

    task automatic test_back_to_back();
        int c0, c1, c2; int n;
        logic [Width+7:0] e0, e1, e2;
        n = wlog.size();
        do_access(OP_WRITE, 6, 32'hAAAA_0001, 1'b1, "b2b0", c0);
        do_access(OP_WRITE, 1, 32'hBBBB_0002, 1'b1, "b2b1", c1);
        do_access(OP_WRITE, 6, 32'hCCCC_0003, 1'b1, "b2b2", c2);
        req_i = 1'b0;
        checks++;
        if (c1 - c0 != 3 || c2 - c1 != 3) begin
            errors++; $display("FAIL b2b spacing: gaps %0d %0d want 3 3", c1 - c0, c2 - c1);
        end
        e0 = {8'd6, 32'hAAAA_0001}; e1 = {8'd1, 32'hBBBB_0002}; e2 = {8'd6, 32'hCCCC_0003};
        checks++;
        if (wlog.size() != n + 3) begin
            errors++; $display("FAIL b2b write count: got %0d want 3", wlog.size() - n);
        end else if (wlog[n] !== e0 || wlog[n+1] !== e1 || wlog[n+2] !== e2) begin
            errors++; $display("FAIL b2b order: got %h %h %h want %h %h %h",
                               wlog[n], wlog[n+1], wlog[n+2], e0, e1, e2);
        end
    endtask

    task automatic test_scrub_alert();
        int waited; int c;
        checks++;
        if (alert_o !== 1'b0) begin
            errors++; $display("FAIL scrub pre alert: got %b want 0", alert_o);
        end
        err_flags[5] = 1'b1;
        waited = 0;
        while (alert_o !== 1'b1 && waited < NumCsr * ScrubPeriod + 4) begin
            @(negedge clk_i); waited++;
        end
        checks++;
        if (alert_o !== 1'b1) begin
            errors++; $display("FAIL scrub alert: got %b after %0d idle cycles want 1", alert_o, waited);
        end
        do_access(OP_READ, 5, 32'h0, 1'b0, "scrub_read5", c);
        repeat (20) @(negedge clk_i);
        err_flags = '0;
        repeat (5) @(negedge clk_i);
        checks++;
        if (alert_o !== 1'b1) begin
            errors++; $display("FAIL alert sticky: got %b want 1", alert_o);
        end
    endtask

    task automatic test_reset_mid_access();
        bit saw_rvalid;
        preload(4, 32'h0000_0055);
        req_i = 1'b1; op_i = OP_WRITE; addr_i = 4'd4; wdata_i = 32'h0000_00AA;
        @(posedge clk_i); @(negedge clk_i);
        req_i = 1'b0;
        checks++;
        if (csr_wr_en_o !== 8'b0001_0000) begin
            errors++; $display("FAIL midreset access: we=%b want 00010000", csr_wr_en_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (csr_wr_en_o !== '0 || csr_wr_data_o !== '0 || rvalid_o !== 1'b0 || gnt_o !== 1'b0 ||
            alert_o !== 1'b0 || rdata_o !== '0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: we=%b wd=%h rv=%b gnt=%b alert=%b rdata=%h err=%b want all 0",
                     csr_wr_en_o, csr_wr_data_o, rvalid_o, gnt_o, alert_o, rdata_o, err_o);
        end
        @(posedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL midreset release gnt: got %b want 1", gnt_o);
        end
        saw_rvalid = 1'b0;
        repeat (4) begin @(negedge clk_i); if (rvalid_o !== 1'b0) saw_rvalid = 1'b1; end
        checks++;
        if (saw_rvalid || mem[4] !== 32'h0000_0055) begin
            errors++; $display("FAIL midreset abort: rvalid_seen=%b csr4=%h want 0 00000055",
                               saw_rvalid, mem[4]);
        end
    endtask

    task automatic test_access_alert();
        int c;
        err_flags[3] = 1'b1;
        do_access(OP_SET, 3, 32'h0000_0001, 1'b0, "access_err3", c);
        err_flags = '0;
        checks++;
        if (alert_o !== 1'b1) begin
            errors++; $display("FAIL access alert: got %b want 1", alert_o);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_clear_zero();
        test_illegal();
        test_hold();
        test_random();
        test_back_to_back();
        test_scrub_alert();
        test_reset_mid_access();
        test_access_alert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
